bisr_weight_preload_sequencer: RTL and testbench

Downstream consumer of the BISR weight-allocation stage. Once allocation reports `recovery_done`, the sequencer walks logical addresses 0..SYSTOLIC_SIZE-1 on the allocation read port. It captures each returned weight row and its mapped physical row, then drives a one-hot row-load strobe into the systolic array. It also flags unrecovered faults, duplicate physical mappings and a stalled allocation stage.

---
 rtl/bisr_pkg.sv | 18 +
 rtl/row_onehot_decode.sv | 14 +
 rtl/bisr_weight_preload_sequencer.sv | 127 ++++++++++++
 tb/tb_bisr_weight_preload_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// Shared types for the BISR weight-preload path: sequencer states and the
// error codes reported to the host once a preload finishes.
package bisr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RECOV,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_UNRECOVERED = 2'b01;
  localparam logic [1:0] ERR_DUP_MAP     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT     = 2'b11;

endpackage

// File: rtl/row_onehot_decode.sv
// Physical row address to one-hot row strobe; shared with the array loader.
module row_onehot_decode #(
  parameter int SYSTOLIC_SIZE = 4,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  output logic [SYSTOLIC_SIZE-1:0] onehot
);

  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_row
    assign onehot[i] = (addr == ADDR_WIDTH'(i));
  end

endmodule

// File: rtl/bisr_weight_preload_sequencer.sv
// Walks the allocation read port after BISR recovery, loads each returned row
// into its mapped physical systolic row and reports recovery/mapping faults.
module bisr_weight_preload_sequencer
  import bisr_pkg::*;
#(
  parameter int SYSTOLIC_SIZE  = 4,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_start,
  input  logic                                  recovery_done,
  input  logic                                  recovery_success,
  output logic [ADDR_WIDTH-1:0]                 read_addr,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] alloc_weights,
  input  logic [ADDR_WIDTH-1:0]                 alloc_mapped_addr,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] pe_weight_data,
  output logic [SYSTOLIC_SIZE-1:0]              pe_row_load_en,
  output logic                                  load_busy,
  output logic                                  load_done,
  output logic                                  load_error,
  output logic [1:0]                            error_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  load_state_e              state_q, state_d;
  logic [TW-1:0]            tmo_cnt;
  logic                     drain_cnt;
  logic                     cap_valid;
  logic [SYSTOLIC_SIZE-1:0] written_mask;
  logic [SYSTOLIC_SIZE-1:0] map_onehot;
  logic                     dup_hit;

  row_onehot_decode #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_dec (
    .addr   (alloc_mapped_addr),
    .onehot (map_onehot)
  );

  assign dup_hit   = |(written_mask & map_onehot);
  assign load_busy = (state_q != ST_IDLE);
  assign load_done = (state_q == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (load_start) state_d = ST_WAIT_RECOV;
      ST_WAIT_RECOV: begin
        if (recovery_done)           state_d = recovery_success ? ST_STREAM : ST_DONE;
        else if (tmo_cnt == TMO_LAST) state_d = ST_DONE;
      end
      ST_STREAM:     if (read_addr == ROW_LAST) state_d = ST_DRAIN;
      ST_DRAIN:      if (drain_cnt) state_d = ST_DONE;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_addr      <= '0;
      pe_weight_data <= '0;
      pe_row_load_en <= '0;
      load_error     <= 1'b0;
      error_code     <= ERR_NONE;
      tmo_cnt        <= '0;
      drain_cnt      <= 1'b0;
      cap_valid      <= 1'b0;
      written_mask   <= '0;
    end else begin
      pe_row_load_en <= '0;
      cap_valid      <= (state_q == ST_STREAM);
      unique case (state_q)
        ST_IDLE: if (load_start) begin
          load_error   <= 1'b0;
          error_code   <= ERR_NONE;
          written_mask <= '0;
          tmo_cnt      <= '0;
        end
        ST_WAIT_RECOV: begin
          // Error code is always clear here: this is the first check of the run.
          if (recovery_done && recovery_success) begin
            read_addr <= '0;
          end else if (recovery_done) begin
            error_code <= ERR_UNRECOVERED;
            load_error <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            error_code <= ERR_TIMEOUT;
            load_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_STREAM: begin
          drain_cnt <= 1'b0;
          if (read_addr != ROW_LAST) read_addr <= read_addr + ADDR_WIDTH'(1);
        end
        ST_DRAIN: drain_cnt <= 1'b1;
        default: ;
      endcase
      // Capture stage: data returned for the address issued one cycle ago.
      if (cap_valid) begin
        pe_weight_data <= alloc_weights;
        if (dup_hit) begin
          load_error <= 1'b1;
          if (error_code == ERR_NONE) error_code <= ERR_DUP_MAP;
        end else begin
          pe_row_load_en <= map_onehot;
          written_mask   <= written_mask | map_onehot;
        end
      end
    end
  end

endmodule

// File: tb/tb_bisr_weight_preload_sequencer.sv
// Bench for the weight-preload sequencer: table-driven runs, hand-written
// timeout/reset sequences and randomized runs against a mapping model.
module tb_bisr_weight_preload_sequencer;

  localparam int N  = 4;
  localparam int WW = 8;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start;
  logic            recovery_done;
  logic            recovery_success;
  logic [AW-1:0]   read_addr;
  logic [N*WW-1:0] alloc_weights;
  logic [AW-1:0]   alloc_mapped_addr;
  logic [N*WW-1:0] pe_weight_data;
  logic [N-1:0]    pe_row_load_en;
  logic            load_busy;
  logic            load_done;
  logic            load_error;
  logic [1:0]      error_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0]   map [N];
    logic [N*WW-1:0] rows [N];
    logic            succ;
    logic            second_start;
    logic [1:0]      exp_err;
    logic [N-1:0]    exp_en [N];
  } entry_t;

  logic [AW-1:0]   map_m  [N];
  logic [N*WW-1:0] rows_m [N];

  always #5 clk = ~clk;

  bisr_weight_preload_sequencer #(
    .SYSTOLIC_SIZE  (N),
    .WEIGHT_WIDTH   (WW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load_start        (load_start),
    .recovery_done     (recovery_done),
    .recovery_success  (recovery_success),
    .read_addr         (read_addr),
    .alloc_weights     (alloc_weights),
    .alloc_mapped_addr (alloc_mapped_addr),
    .pe_weight_data    (pe_weight_data),
    .pe_row_load_en    (pe_row_load_en),
    .load_busy         (load_busy),
    .load_done         (load_done),
    .load_error        (load_error),
    .error_code        (error_code)
  );

  // Allocation stage model: one-cycle registered read.
  always @(posedge clk) begin
    alloc_weights     <= rows_m[read_addr];
    alloc_mapped_addr <= map_m[read_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each logical row lands on its mapped physical row unless that
  // row was already written; the first fault seen is the one reported.
  function automatic entry_t model(input entry_t e);
    entry_t r = e;
    logic [N-1:0] seen = '0;
    r.exp_err = e.succ ? 2'b00 : 2'b01;
    for (int k = 0; k < N; k++) begin
      if (seen[e.map[k]]) begin
        r.exp_en[k] = '0;
        if (r.exp_err == 2'b00) r.exp_err = 2'b10;
      end else begin
        r.exp_en[k] = N'(1) << e.map[k];
        seen[e.map[k]] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic run_entry(input entry_t e, input string tag);
    map_m = e.map;
    rows_m = e.rows;
    recovery_done = 1'b1;
    recovery_success = e.succ;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    chk({tag, "_busy_c1"}, load_busy, 1);
    chk({tag, "_err_clear"}, {load_error, error_code}, 0);
    if (!e.succ) begin
      @(negedge clk);
      chk({tag, "_nr_done"}, load_done, 1);
      chk({tag, "_nr_code"}, error_code, e.exp_err);
      chk({tag, "_nr_err"}, load_error, 1);
      chk({tag, "_nr_en"}, pe_row_load_en, 0);
      @(negedge clk);
      chk({tag, "_nr_idle"}, {load_busy, load_done}, 0);
    end else begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        load_start = (e.second_start && c == 1);
        chk({tag, "_raddr"}, read_addr, (c < N) ? c : N - 1);
        chk({tag, "_en"}, pe_row_load_en, (c >= 2 && c < N + 2) ? e.exp_en[c-2] : 0);
        if (c >= 2 && c < N + 2) chk({tag, "_data"}, pe_weight_data, e.rows[c-2]);
        chk({tag, "_done"}, load_done, c == N + 2);
        chk({tag, "_busy"}, load_busy, c <= N + 2);
        if (c == N + 2) begin
          chk({tag, "_code"}, error_code, e.exp_err);
          chk({tag, "_lerr"}, load_error, e.exp_err != 2'b00);
        end
      end
      load_start = 1'b0;
    end
  endtask

  entry_t tab [5];

  initial begin
    entry_t e;
    int n;
    int done_seen;
    tab[0].map  = '{2'd1, 2'd0, 2'd3, 2'd2};
    tab[0].rows = '{{8'd42, 8'd32, 8'd22, 8'd0}, {8'd43, 8'd0, 8'd23, 8'd0},
                    {8'd44, 8'd34, 8'd24, 8'd14}, {8'd45, 8'd35, 8'd0, 8'd15}};
    tab[0].succ = 1'b1; tab[0].second_start = 1'b0; tab[0].exp_err = 2'b00;
    tab[0].exp_en = '{4'b0010, 4'b0001, 4'b1000, 4'b0100};
    tab[1] = tab[0]; tab[1].second_start = 1'b1;
    tab[2] = tab[0];
    tab[2].map = '{2'd0, 2'd2, 2'd1, 2'd2};
    tab[2].exp_err = 2'b10;
    tab[2].exp_en = '{4'b0001, 4'b0100, 4'b0010, 4'b0000};
    tab[3] = tab[0]; tab[3].succ = 1'b0; tab[3].exp_err = 2'b01;
    tab[4] = tab[0];

    rst = 1'b1; load_start = 1'b0; recovery_done = 1'b0; recovery_success = 1'b0;
    map_m = tab[0].map; rows_m = tab[0].rows;
    repeat (2) @(negedge clk);
    chk("rst_outs", {read_addr, pe_weight_data, pe_row_load_en, load_busy, load_done,
                     load_error, error_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", load_busy, 0);

    for (int i = 0; i < 5; i++) run_entry(tab[i], $sformatf("tab%0d", i));

    // Timeout: recovery never completes.
    recovery_done = 1'b0; recovery_success = 1'b0;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    n = 1;
    while (!load_done && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycle", n, 9);
    chk("tmo_code", error_code, 2'b11);
    chk("tmo_lerr", load_error, 1);

    // Reset in the middle of streaming.
    @(negedge clk);
    map_m = tab[0].map; rows_m = tab[0].rows;
    recovery_done = 1'b1; recovery_success = 1'b1;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", pe_row_load_en, 4'b0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {read_addr, pe_weight_data, pe_row_load_en, load_busy, load_done,
                         load_error, error_code}, 0);
    @(negedge clk); rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (load_done || load_busy) done_seen++;
    end
    chk("post_rst_quiet", done_seen, 0);

    // Randomized runs against the mapping model.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) begin
        e.map[k]  = AW'($urandom_range(N - 1));
        e.rows[k] = $urandom;
      end
      e.succ = ($urandom_range(9) != 0);
      e.second_start = $urandom_range(1);
      e = model(e);
      run_entry(e, $sformatf("rnd%0d", r));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
